// File: rtl/div_pkg.sv
// Shared widths and state encoding for the iterative restoring divider.
package div_pkg;

    localparam int N  = 8;
    localparam int W  = 2 * N;
    localparam int CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then subtract the divisor and keep the difference when it does not go negative.
module div_step
    import div_pkg::*;
(
    input  logic [N:0]   p_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N:0]   p_o,
    output logic         q_o
);

    logic [N+1:0] shifted_s;
    logic [N+1:0] trial_s;

    // Trial subtraction; the partial remainder stays below the divisor, so the
    // top bit of the (N+2)-bit difference is a reliable borrow/sign flag.
    always_comb begin
        shifted_s = {p_i, bit_i};
        trial_s   = shifted_s - {2'b00, divisor_i};
        if (trial_s[N+1]) begin
            p_o = shifted_s[N:0];
            q_o = 1'b0;
        end else begin
            p_o = trial_s[N:0];
            q_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, 2N/N -> 2N quotient and N remainder, one bit per clock,
// with a start/busy/done handshake and registered results.
module seq_divider
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    p_q, p_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          div_zero_q, div_zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [N:0]    step_p_s;
    logic          step_q_s;

    div_step u_step (
        .p_i       (p_q),
        .bit_i     (sh_q[W-1]),
        .divisor_i (dvs_q),
        .p_o       (step_p_s),
        .q_o       (step_q_s)
    );

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        sh_d        = sh_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != {N{1'b0}}) begin
                        state_d = RUN;
                        cnt_d   = 5'd15;
                        p_d     = {(N+1){1'b0}};
                        sh_d    = dividend;
                        dvs_d   = divisor;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = {W{1'b1}};
                        remainder_d = dividend[N-1:0];
                        div_zero_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // sh_q shifts dividend bits out of the top while quotient bits enter below
                p_d  = step_p_s;
                sh_d = {sh_q[W-2:0], step_q_s};
                if (cnt_q == 5'd0) begin
                    state_d     = DONE;
                    quotient_d  = {sh_q[W-2:0], step_q_s};
                    remainder_d = step_p_s[N-1:0];
                    div_zero_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            p_q         <= {(N+1){1'b0}};
            sh_q        <= {W{1'b0}};
            dvs_q       <= {N{1'b0}};
            quotient_q  <= {W{1'b0}};
            remainder_q <= {N{1'b0}};
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            sh_q        <= sh_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized divisions
// compared against plain integer division.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the defined divide-by-zero result.
    task automatic ref_div(input logic [15:0] dd, input logic [7:0] dv,
                           output logic [15:0] q, output logic [7:0] r,
                           output logic dz, output int lat);
        if (dv == 8'd0) begin
            q = 16'hFFFF; r = dd[7:0]; dz = 1'b1; lat = 1;
        end else begin
            q = 16'(int'(dd) / int'(dv));
            r = 8'(int'(dd) % int'(dv));
            dz = 1'b0; lat = 17;
        end
    endtask

    // Issue one division, scramble operands after the start cycle, wait for done.
    task automatic run_div(input string tag, input logic [15:0] dd, input logic [7:0] dv);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz;
        int          elat;
        int          lat;
        ref_div(dd, dv, eq, er, edz, elat);
        @(negedge clk);
        dividend = dd; divisor = dv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
        chk({tag, "_remainder"}, {24'd0, remainder}, {24'd0, er});
        chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          done_cnt;
        logic [15:0] cap_q;
        logic [7:0]  cap_r;

        rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quotient", {16'd0, quotient}, 32'd0);
        chk("reset_remainder", {24'd0, remainder}, 32'd0);
        chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;

        run_div("d1000_7", 16'd1000, 8'd7);
        run_div("dffff_1", 16'hFFFF, 8'h01);
        run_div("d0_5", 16'h0000, 8'h05);
        run_div("dfe_ff", 16'h00FE, 8'hFF);
        run_div("dzero", 16'h1234, 8'h00);
        run_div("d10_3", 16'd10, 8'd3);

        // Hold: results stay put while idle.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("hold_quotient", {16'd0, quotient}, 32'd3);
            chk("hold_remainder", {24'd0, remainder}, 32'd1);
            chk("hold_done_low", {31'd0, done}, 32'd0);
        end

        // Start while busy is ignored.
        @(negedge clk);
        dividend = 16'd100; divisor = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        dividend = 16'd50; divisor = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0; cap_q = 16'd0; cap_r = 8'd0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                done_cnt++;
                cap_q = quotient;
                cap_r = remainder;
            end
            @(negedge clk);
        end
        chk("busy_start_done_count", 32'(done_cnt), 32'd1);
        chk("busy_start_quotient", {16'd0, cap_q}, 32'd11);
        chk("busy_start_remainder", {24'd0, cap_r}, 32'd1);

        // Reset at RUN cycle 8 discards the division.
        dividend = 16'd200; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_done", {31'd0, done}, 32'd0);
        chk("mid_reset_quotient", {16'd0, quotient}, 32'd0);
        chk("mid_reset_remainder", {24'd0, remainder}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("mid_reset_no_done", 32'(done_cnt), 32'd0);
        run_div("d77_7", 16'd77, 8'd7);

        // Reset and start together: start is dropped.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 16'd500; divisor = 8'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || done) done_cnt++;
            @(negedge clk);
        end
        chk("rst_start_dropped", 32'(done_cnt), 32'd0);

        // Inverse of the 8x8 multiplier, back-to-back.
        for (int i = 0; i < 64; i++) begin
            for (int j = 1; j < 64; j++) begin
                run_div("inverse", 16'(i * j), 8'(j));
            end
        end

        // Random operands, occasionally a zero divisor.
        for (int k = 0; k < 150; k++) begin
            logic [7:0] dv;
            dv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_div("random", 16'($urandom), dv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
